// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared FSM states, APB region map and AHB HTRANS encodings for the AHB-to-APB bridge
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam logic [31:0] REGION0_BASE     = 32'h8000_0000;
    localparam logic [31:0] REGION1_BASE     = 32'h8400_0000;
    localparam logic [31:0] REGION2_BASE     = 32'h8800_0000;
    localparam logic [31:0] REGION_SIZE_MASK = 32'h03FF_FFFF;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/apb_sel_decode.sv
// apb_sel_decode: maps the registered APB address onto a one-hot completer select (000 when unmapped)
module apb_sel_decode
    import apb_bridge_pkg::*;
(
    input  logic [31:0] paddr,
    output logic [2:0]  psel
);

    logic [31:0] base;

    // strip the in-region offset and compare against each region base
    always_comb begin
        base = paddr & ~REGION_SIZE_MASK;
        psel = {base == REGION2_BASE, base == REGION1_BASE, base == REGION0_BASE};
    end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// apb_bridge_ctrl: AHB-to-APB bridge control FSM (IDLE/SETUP/ACCESS); define APB_PREADY_EN to let PREADY stretch ACCESS
module apb_bridge_ctrl
    import apb_bridge_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELAPB,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic        HREADYIN,
    input  logic        PREADY,
    output logic        HREADYOUT,
    output logic [2:0]  PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR
);

    state_e      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [2:0]  sel;
    logic        valid, done, capture;

    apb_sel_decode u_sel_decode (
        .paddr (paddr_q),
        .psel  (sel)
    );

`ifdef APB_PREADY_EN
    // unmapped accesses have no completer to answer, so they never wait on PREADY
    always_comb done = PREADY | ~|sel;
`else
    logic unused_pready;
    assign unused_pready = PREADY;
    always_comb done = 1'b1;
`endif

    // next-state and capture decision; sampling only happens in IDLE or on a completing ACCESS
    always_comb begin
        valid    = HSELAPB & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ)) & HREADYIN;
        capture  = valid & ((state_q == IDLE) | ((state_q == ACCESS) & done));
        state_d  = capture                         ? SETUP  :
                   (state_q == SETUP)              ? ACCESS :
                   ((state_q == ACCESS) & ~done)   ? ACCESS : IDLE;
        paddr_d  = capture ? HADDR  : paddr_q;
        pwrite_d = capture ? HWRITE : pwrite_q;
    end

    // state and transfer attributes; reset abandons any transfer in flight
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
        end
    end

    // APB/AHB outputs decoded straight from the registered state and address
    always_comb begin
        PSEL      = (state_q == IDLE) ? 3'b000 : sel;
        PENABLE   = (state_q == ACCESS);
        HREADYOUT = (state_q == IDLE) | ((state_q == ACCESS) & done);
        PWRITE    = pwrite_q;
        PADDR     = paddr_q;
    end

endmodule

// File: doc/apb_bridge_ctrl.md
APB_BRIDGE_CTRL -- requirements
Module: apb_bridge_ctrl

Interface
REQ-001 SHALL provide one clock and an asynchronous, active-low reset: HCLK and HRESETn.
REQ-002 HCLK  in  1  bridge clock; all state changes on its rising edge.
REQ-003 HRESETn  in  1  asynchronous active-low reset.
REQ-004 HSELAPB  in  1  AHB slave select for the APB bridge region.
REQ-005 HTRANS  in  2  AHB transfer type; NONSEQ=2'b10 and SEQ=2'b11 are valid, IDLE and BUSY are ignored.
REQ-006 HWRITE  in  1  AHB direction, 1 = write.
REQ-007 HADDR  in  32  AHB address-phase address.
REQ-008 HREADYIN  in  1  AHB bus ready; qualifies address-phase sampling.
REQ-009 PREADY  in  1  APB completer ready; used only when APB_PREADY_EN is defined, ignored otherwise.
REQ-010 HREADYOUT  out  1  bridge ready to AHB; 0 inserts wait states.
REQ-011 PSEL  out  3  one-hot APB completer select.
REQ-012 PENABLE  out  1  APB access-phase strobe.
REQ-013 PWRITE  out  1  registered transfer direction.
REQ-014 PADDR  out  32  registered transfer address.

Function
REQ-015 A valid transfer SHALL be HSELAPB & HTRANS[1] & HREADYIN sampled at a rising HCLK edge.
REQ-016 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-017 IDLE: on a valid transfer, capture HADDR->PADDR and HWRITE->PWRITE, and go to SETUP; otherwise stay in IDLE.
REQ-018 SETUP: PSEL = decode(PADDR), PENABLE=0, HREADYOUT=0; always go to ACCESS after exactly one cycle.
REQ-019 ACCESS: PSEL held, PENABLE=1; the transfer completes when PREADY=1 (APB_PREADY_EN) or unconditionally (no macro).
REQ-020 On completion: HREADYOUT=1 that cycle. If a valid transfer is sampled on the same edge, capture it and go to SETUP. Otherwise go to IDLE with PSEL=000 and PENABLE=0.
REQ-021 ACCESS without completion SHALL hold PSEL, PENABLE, PADDR and PWRITE stable, with HREADYOUT=0.
REQ-022 HREADYOUT SHALL be 1 in IDLE; PSEL SHALL be 000 in IDLE.
REQ-023 Decode map:
- 0x8000_0000-0x83FF_FFFF -> PSEL=001
- 0x8400_0000-0x87FF_FFFF -> PSEL=010
- 0x8800_0000-0x8BFF_FFFF -> PSEL=100
- any other address -> PSEL=000, and the FSM still sequences SETUP->ACCESS and completes in one ACCESS cycle regardless of PREADY.
REQ-024 Latency SHALL be 2 HCLK cycles from the address-phase edge to HREADYOUT=1 with zero PREADY wait states, and 2+N cycles with N wait states.
REQ-025 Valid transfers presented while HREADYOUT=0 SHALL NOT occur (HREADYIN=0); the controller SHALL NOT sample during SETUP or non-completing ACCESS.
REQ-026 PWRITE and PADDR SHALL change only on a capture edge.

Reset
REQ-027 On HRESETn=0: state=IDLE, PSEL=000, PENABLE=0, PWRITE=0, PADDR=0, HREADYOUT=1, immediately and independent of HCLK.
REQ-028 Reset during SETUP or ACCESS SHALL abandon the transfer with no retry; the first edge after release SHALL sample as IDLE.

Configuration
REQ-029 Macro APB_PREADY_EN defined: ACCESS extends while PREADY=0, with unbounded wait.
REQ-030 Macro APB_PREADY_EN undefined: ACCESS is always exactly one cycle; the PREADY port remains present but unused.

Structure
REQ-031 Shared package apb_bridge_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS), the three region base addresses, the region size mask and the HTRANS encodings.
REQ-032 Address decode SHALL be one combinational sub-module apb_sel_decode (PADDR in, PSEL out), instantiated once.

Verification
REQ-033 Single write to 0x8000_0010, PREADY=1:
- SETUP cycle: PSEL=001, PENABLE=0, HREADYOUT=0
- ACCESS cycle: PENABLE=1, HREADYOUT=1
- then IDLE with PSEL=000.
REQ-034 Back-to-back read to 0x8400_0004 then write to 0x8800_0008, no idle between: second SETUP directly follows first ACCESS; PSEL 010 then 100; PWRITE 0 then 1.
REQ-035 APB_PREADY_EN defined, PREADY=0 for 3 cycles: ACCESS lasts 4 cycles, HREADYOUT=0 for 4 cycles total, PADDR and PSEL stable throughout.
REQ-036 Unmapped address 0x9000_0000: PSEL=000 in SETUP and ACCESS; completes in 2 cycles with PREADY held 0.
REQ-037 HRESETn asserted mid-ACCESS: outputs reach reset values without an HCLK edge; after release, the next valid transfer to 0x8000_0000 sequences normally.
REQ-038 HTRANS=BUSY with HSELAPB=1, or HREADYIN=0 with NONSEQ: no capture, FSM stays IDLE, PADDR unchanged.
